// File: rtl/sd_multi_sector_reader.sv
// sd_multi_sector_reader: reads a run of consecutive SD sectors through an
// sd_controller-style byte port into a first-word-fall-through FIFO.
// Downstream logic drains that FIFO over a valid/ready byte stream. A read
// strobe is issued only once a whole sector fits in the FIFO, so back-pressure
// never loses data.
module sd_multi_sector_reader #(
  parameter int BLOCK_BYTES = 512,
  parameter int FIFO_DEPTH  = 1024,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      start_sector,
  input  logic [CNT_W-1:0] num_sectors,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       error_code,
  output logic [CNT_W-1:0] sectors_done,
  input  logic             sd_ready,
  output logic             sd_rd,
  output logic [31:0]      sd_address,
  input  logic             sd_byte_available,
  input  logic [7:0]       sd_dout,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BLOCK_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [AW:0]      DEPTH_C     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      BLOCK_C     = (AW+1)'(BLOCK_BYTES);
  localparam logic [AW:0]      CNT_ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE_C   = AW'(1);
  localparam logic [BW-1:0]    LAST_BYTE_C = BW'(BLOCK_BYTES - 1);
  localparam logic [BW-1:0]    BYTE_ONE_C  = BW'(1);
  localparam logic [TW-1:0]    TMO_DATA_C  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0]    TMO_READY_C = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]    TMO_MAX_C   = {TW{1'b1}};
  localparam logic [TW-1:0]    TMO_ONE_C   = TW'(1);
  localparam logic [CNT_W-1:0] SECT_ONE_C  = CNT_W'(1);

  localparam logic [1:0] ERR_NONE_C  = 2'd0;
  localparam logic [1:0] ERR_READY_C = 2'd1;
  localparam logic [1:0] ERR_DATA_C  = 2'd2;
  localparam logic [1:0] ERR_OVF_C   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_RECV  = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state_q,     state_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             error_q,     error_d;
  logic [1:0]       err_code_q,  err_code_d;
  logic [CNT_W-1:0] sect_done_q, sect_done_d;
  logic [CNT_W-1:0] num_left_q,  num_left_d;
  logic             sd_rd_q,     sd_rd_d;
  logic [31:0]      addr_q,      addr_d;
  logic [BW-1:0]    byte_cnt_q,  byte_cnt_d;
  logic [TW-1:0]    tmo_q,       tmo_d;
  logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [AW:0]      count_q,     count_d;

  logic [8:0]       fifo_mem [FIFO_DEPTH];
  logic [8:0]       head_s;
  logic [AW:0]      free_s;
  logic             valid_s;
  logic             rd_en_s;
  logic             wr_en_s;
  logic             wr_tag_s;
  logic             flush_s;

  // Saturating increment so a stalled counter never wraps back to a safe value.
  function automatic logic [TW-1:0] tmo_inc(input logic [TW-1:0] v);
    if (v == TMO_MAX_C) begin
      return v;
    end else begin
      return v + TMO_ONE_C;
    end
  endfunction

  assign head_s  = fifo_mem[rd_ptr_q];
  assign valid_s = (count_q != '0);
  assign free_s  = DEPTH_C - count_q;
  assign rd_en_s = valid_s & m_ready;

  // Run control: next state, sector bookkeeping, timeouts and error capture.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_code_d  = err_code_q;
    sect_done_d = sect_done_q;
    num_left_d  = num_left_q;
    addr_d      = addr_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    wr_en_s     = 1'b0;
    wr_tag_s    = (byte_cnt_q == LAST_BYTE_C) && (num_left_q == SECT_ONE_C);
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            addr_d      = start_sector;
            num_left_d  = num_sectors;
            sect_done_d = '0;
            error_d     = 1'b0;
            err_code_d  = ERR_NONE_C;
            if (num_sectors == '0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_WAIT: begin
          if (sd_ready) begin
            if (free_s >= BLOCK_C) begin
              state_d = S_ISSUE;
            end else begin
              state_d = S_WAIT;
            end
          end else if (tmo_q >= TMO_READY_C) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = ERR_READY_C;
          end else begin
            tmo_d = tmo_inc(tmo_q);
          end
        end
        S_ISSUE: begin
          byte_cnt_d = '0;
          state_d    = S_RECV;
        end
        S_RECV: begin
          if (sd_byte_available) begin
            if ((count_q == DEPTH_C) && !rd_en_s) begin
              state_d    = S_ERR;
              error_d    = 1'b1;
              err_code_d = ERR_OVF_C;
            end else begin
              wr_en_s    = 1'b1;
              byte_cnt_d = byte_cnt_q + BYTE_ONE_C;
              if (byte_cnt_q == LAST_BYTE_C) begin
                sect_done_d = sect_done_q + SECT_ONE_C;
                num_left_d  = num_left_q - SECT_ONE_C;
                addr_d      = addr_q + 32'd1;
                if (num_left_q == SECT_ONE_C) begin
                  state_d = S_DRAIN;
                end else begin
                  state_d = S_WAIT;
                end
              end else begin
                state_d = S_RECV;
              end
            end
          end else if (tmo_q >= TMO_DATA_C) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = ERR_DATA_C;
          end else begin
            tmo_d = tmo_inc(tmo_q);
          end
        end
        S_DRAIN: begin
          if (rd_en_s && head_s[8]) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    if (sd_byte_available || (state_d != state_q)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_d;
    end
    flush_s = abort || (state_d == S_ERR);
    busy_d  = (state_d == S_WAIT) || (state_d == S_ISSUE) ||
              (state_d == S_RECV) || (state_d == S_DRAIN);
    sd_rd_d = (state_d == S_ISSUE);
  end

  // FIFO pointers and occupancy; a flush empties the FIFO in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage: byte plus end-of-run tag.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      fifo_mem[wr_ptr_q] <= {wr_tag_s, sd_dout};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE_C;
      sect_done_q <= '0;
      num_left_q  <= '0;
      sd_rd_q     <= 1'b0;
      addr_q      <= 32'd0;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      sect_done_q <= sect_done_d;
      num_left_q  <= num_left_d;
      sd_rd_q     <= sd_rd_d;
      addr_q      <= addr_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign error_code   = err_code_q;
  assign sectors_done = sect_done_q;
  assign sd_rd        = sd_rd_q;
  assign sd_address   = addr_q;
  assign m_valid      = valid_s;
  assign m_data       = valid_s ? head_s[7:0] : 8'h00;
  assign m_last       = valid_s & head_s[8];

endmodule

// File: tb/tb_sd_multi_sector_reader.sv
// Bench for sd_multi_sector_reader: a behavioural SD controller feeds bytes,
// a queue scoreboard holds the bytes expected downstream, and run-level
// expectations (pulse counts, addresses, totals) come from plain arithmetic.
module tb_sd_multi_sector_reader;

  localparam int BLK = 512;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] start_sector;
  logic [15:0] num_sectors;
  logic        busy, done, error;
  logic [1:0]  error_code;
  logic [15:0] sectors_done;
  logic        sd_ready, sd_rd;
  logic [31:0] sd_address;
  logic        sd_byte_available;
  logic [7:0]  sd_dout;
  logic [7:0]  m_data;
  logic        m_valid, m_ready, m_last;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_addrs[$];
  int          rd_pulses = 0, model_bytes = 0, rx_count = 0, done_cnt = 0;
  int          total_bytes = 0, stop_after = -1, rdy_mode = 0;
  logic [7:0]  data_ofs = 8'h00;
  bit          rand_data = 1'b0, ready_stuck = 1'b0, sd_kill = 1'b0, model_busy = 1'b0;

  sd_multi_sector_reader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_sector(start_sector), .num_sectors(num_sectors),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .sectors_done(sectors_done), .sd_ready(sd_ready), .sd_rd(sd_rd),
    .sd_address(sd_address), .sd_byte_available(sd_byte_available),
    .sd_dout(sd_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // SD controller model: answers each sd_rd with one sector of bytes.
  initial begin : sd_model
    sd_ready = 1'b1; sd_byte_available = 1'b0; sd_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (sd_rd === 1'b1 && !sd_kill) begin
        model_busy = 1'b1;
        rd_pulses++;
        rd_addrs.push_back(sd_address);
        sd_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        for (int i = 0; i < BLK; i++) begin
          if (sd_kill || (stop_after >= 0 && model_bytes >= stop_after)) break;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          sd_dout = rand_data ? 8'($urandom) : (8'(model_bytes) + data_ofs);
          sd_byte_available = 1'b1;
          exp_q.push_back(sd_dout);
          model_bytes++;
          @(negedge clk);
          sd_byte_available = 1'b0;
        end
        model_busy = 1'b0;
      end
      sd_ready = !ready_stuck;
    end
  end

  // Downstream consumer back-pressure: 0 = stalled, 1 = always ready, 2 = random.
  initial begin : ready_drv
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
      else               m_ready = (rdy_mode == 1);
    end
  end

  // Stream monitor: order, tag placement, hold stability, done pulses.
  initial begin : monitor
    logic [7:0] prev_d, exp_b;
    logic       prev_v, prev_r, prev_l;
    bit         have_prev;
    have_prev = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (have_prev && prev_v && !prev_r && m_valid) begin
          check("hold_data", 64'(m_data), 64'(prev_d));
          check("hold_last", 64'(m_last), 64'(prev_l));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            check("m_data", 64'(m_data), 64'(exp_b));
            check("m_last", 64'(m_last), 64'(rx_count == total_bytes - 1));
          end
          rx_count++;
        end
        prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
        have_prev = 1'b1;
      end
    end
  end

  task automatic start_run(input logic [31:0] sec, input logic [15:0] num);
    exp_q.delete(); rd_addrs.delete();
    rd_pulses = 0; model_bytes = 0; rx_count = 0; done_cnt = 0;
    total_bytes = int'(num) * BLK;
    @(posedge clk); #1;
    start_sector = sec; num_sectors = num; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic quiesce_model();
    int cyc = 0;
    sd_kill = 1'b1;
    while (model_busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("model_quiesce", 64'(model_busy), 64'd0);
    repeat (2) @(negedge clk);
    sd_kill = 1'b0;
  endtask

  task automatic check_full_run(input string tag, input logic [31:0] sec, input int num);
    repeat (5) @(negedge clk);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_rd_pulses"}, 64'(rd_pulses), 64'(num));
    for (int i = 0; i < rd_addrs.size() && i < num; i++)
      check({tag, "_addr"}, 64'(rd_addrs[i]), 64'(sec + 32'(i)));
    check({tag, "_rx_count"}, 64'(rx_count), 64'(num * BLK));
    check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_sectors_done"}, 64'(sectors_done), 64'(num));
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_code"}, 64'(error_code), 64'd0);
    check({tag, "_sectors"}, 64'(sectors_done), 64'd0);
    check({tag, "_sd_rd"}, 64'(sd_rd), 64'd0);
    check({tag, "_addr"}, 64'(sd_address), 64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_last"}, 64'(m_last), 64'd0);
  endtask

  initial begin : main
    int          k;
    logic [31:0] sec;
    int          num;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_sector = 32'd0; num_sectors = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: three sectors from 5, counting byte pattern, consumer always ready.
    rdy_mode = 1; rand_data = 1'b0; data_ofs = 8'h00;
    start_run(32'd5, 16'd3);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(20000, "t1");
    check_full_run("t1", 32'd5, 3);

    // T2: stalled consumer fills the FIFO, so the third read is withheld.
    rdy_mode = 0; rand_data = 1'b1;
    start_run(32'h40, 16'd3);
    k = 0;
    while (model_bytes < 2 * BLK && k < 10000) begin @(negedge clk); k++; end
    check("t2_filled", 64'(model_bytes), 64'(2 * BLK));
    repeat (200) @(negedge clk);
    check("t2_rd_withheld", 64'(rd_pulses), 64'd2);
    check("t2_sectors_mid", 64'(sectors_done), 64'd2);
    check("t2_m_valid", 64'(m_valid), 64'd1);
    check("t2_busy_mid", 64'(busy), 64'd1);
    if (exp_q.size() > 0) check("t2_head", 64'(m_data), 64'(exp_q[0]));
    rdy_mode = 2;
    wait_done(20000, "t2");
    check_full_run("t2", 32'h40, 3);

    // T3: zero sectors gives an immediate done with no reads.
    start_run(32'd9, 16'd0);
    @(negedge clk);
    check("t3_done", 64'(done), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("t3_done_pulse", 64'(done), 64'd0);
    repeat (20) @(negedge clk);
    check("t3_no_rd", 64'(rd_pulses), 64'd0);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);

    // T4: controller never ready -> ready timeout, then a clean run.
    rdy_mode = 1; ready_stuck = 1'b1;
    repeat (2) @(negedge clk);
    start_run(32'd100, 16'd1);
    k = 0;
    while (!error && k < 1000) begin @(negedge clk); k++; end
    check("t4_error", 64'(error), 64'd1);
    check("t4_code", 64'(error_code), 64'd1);
    check("t4_window", 64'((k - 1 >= TMO) && (k - 1 <= TMO + 3)), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_no_rd", 64'(rd_pulses), 64'd0);
    ready_stuck = 1'b0;
    repeat (2) @(negedge clk);
    start_run(32'd200, 16'd1);
    @(negedge clk);
    check("t4_err_cleared", 64'(error), 64'd0);
    check("t4_code_cleared", 64'(error_code), 64'd0);
    wait_done(20000, "t4");
    check_full_run("t4", 32'd200, 1);

    // T5a: controller stops after 200 bytes -> data timeout, FIFO flushed.
    rdy_mode = 0; stop_after = 200;
    start_run(32'h1000, 16'd1);
    k = 0;
    while (!error && k < 3000) begin @(negedge clk); k++; end
    check("t5_error", 64'(error), 64'd1);
    check("t5_code", 64'(error_code), 64'd2);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_flushed", 64'(m_valid), 64'd0);
    check("t5_bytes", 64'(model_bytes), 64'd200);
    quiesce_model();
    stop_after = -1;

    // T5b: abort mid-sector -> idle next cycle, no done.
    rdy_mode = 1;
    start_run(32'h2000, 16'd2);
    @(negedge clk);
    check("t5_start_clears", 64'(error), 64'd0);
    k = 0;
    while (model_bytes < 100 && k < 3000) begin @(negedge clk); k++; end
    check("t5_mid_recv", 64'(model_bytes >= 100), 64'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_valid", 64'(m_valid), 64'd0);
    check("t5_abort_rd", 64'(sd_rd), 64'd0);
    quiesce_model();
    repeat (20) @(negedge clk);
    check("t5_abort_no_done", 64'(done_cnt), 64'd0);
    check("t5_abort_idle", 64'(busy), 64'd0);

    // T6: address wrap, then reset in the middle of the second sector.
    rdy_mode = 2;
    start_run(32'hFFFF_FFFF, 16'd2);
    k = 0;
    while (rd_pulses < 2 && k < 10000) begin @(negedge clk); k++; end
    check("t6_rd_pulses", 64'(rd_pulses), 64'd2);
    if (rd_addrs.size() >= 2) begin
      check("t6_addr0", 64'(rd_addrs[0]), 64'hFFFF_FFFF);
      check("t6_addr1", 64'(rd_addrs[1]), 64'h0000_0000);
    end
    k = 0;
    while (model_bytes < BLK + 88 && k < 3000) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    quiesce_model();

    // Randomized full runs: random start sector, count and data.
    for (int r = 0; r < 2; r++) begin
      sec = $urandom;
      num = int'($urandom_range(1, 3));
      rdy_mode = 2;
      start_run(sec, 16'(num));
      wait_done(30000, "rnd");
      check_full_run("rnd", sec, num);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
